stack_ctrl: RTL

Sequencer for the 8-bit stack pointer and the 256-entry scratch RAM.
- Turns single-cycle PUSH, POP and LDSP requests from the control unit into the correct ordering of SP_LD/SP_INCR/SP_DECR strobes and scratch-RAM address/write-enable.
- Tracks stack occupancy for full/empty status.
- Sits between the control unit and the StackPointer/scratch-RAM pair.

---
 rtl/stack_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences SP strobes and scratch-RAM access for PUSH/POP/LDSP.
// Optional STACK_GUARD_EN adds a FAULT state for overflow/underflow.
module stack_ctrl #(
  parameter int DW = 10,
  parameter int STACK_SIZE = 256
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PUSH_REQ,
  input  logic          POP_REQ,
  input  logic          LDSP_REQ,
  input  logic [7:0]    LDSP_VAL,
  input  logic [DW-1:0] PUSH_DATA,
  output logic [DW-1:0] POP_DATA,
  output logic          BUSY,
  output logic          DONE,
  input  logic [7:0]    SP_VAL,
  output logic          SP_LD,
  output logic          SP_INCR,
  output logic          SP_DECR,
  output logic [7:0]    SP_DATA,
  output logic [7:0]    SCR_ADDR,
  output logic          SCR_WE,
  output logic [DW-1:0] SCR_DIN,
  input  logic [DW-1:0] SCR_DOUT,
  output logic [8:0]    DEPTH,
  output logic          FULL,
  output logic          EMPTY,
  output logic          ERR
);

  localparam logic [8:0] SMAX = 9'(STACK_SIZE);

`ifdef STACK_GUARD_EN
  typedef enum logic [2:0] {
    IDLE, PUSH, POP_RD, POP_WB, LDSP, FAULT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, PUSH, POP_RD, POP_WB, LDSP
  } state_t;
`endif

  state_t        state;
  state_t        nstate;
  logic [DW-1:0] data_q;
  logic [7:0]    val_q;
  logic [DW-1:0] pop_q;
  logic [8:0]    depth_q;
  logic          any_req;

  assign any_req = PUSH_REQ | POP_REQ | LDSP_REQ;

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nstate;
  end

  // next state: IDLE picks one request, LDSP > POP > PUSH
  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        priority case (1'b1)
          LDSP_REQ: nstate = LDSP;
`ifdef STACK_GUARD_EN
          POP_REQ:  nstate = EMPTY ? FAULT : POP_RD;
          PUSH_REQ: nstate = FULL ? FAULT : PUSH;
`else
          POP_REQ:  nstate = POP_RD;
          PUSH_REQ: nstate = PUSH;
`endif
          default:  nstate = IDLE;
        endcase
      end
      POP_RD:  nstate = POP_WB;
      default: nstate = IDLE;
    endcase
  end

  // strobes decode straight from state so reset kills them at once
  always_comb begin
    BUSY     = (state != IDLE);
    DONE     = 1'b0;
    SP_LD    = 1'b0;
    SP_INCR  = 1'b0;
    SP_DECR  = 1'b0;
    SP_DATA  = val_q;
    SCR_ADDR = SP_VAL;
    SCR_WE   = 1'b0;
    SCR_DIN  = data_q;
    case (state)
      PUSH: begin
        SCR_ADDR = SP_VAL - 8'd1;
        SCR_WE   = 1'b1;
        SP_DECR  = 1'b1;
        DONE     = 1'b1;
      end
      POP_WB: begin
        SP_INCR = 1'b1;
        DONE    = 1'b1;
      end
      LDSP: begin
        SP_LD = 1'b1;
        DONE  = 1'b1;
      end
`ifdef STACK_GUARD_EN
      FAULT: DONE = 1'b1;
`endif
      default: ;
    endcase
  end

  // capture operands for whichever request IDLE accepts
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q <= '0;
      val_q  <= '0;
    end else if (state == IDLE && any_req) begin
      data_q <= PUSH_DATA;
      val_q  <= LDSP_VAL;
    end
  end

  // popped word lands one cycle after the read address
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 pop_q <= '0;
    else if (state == POP_WB) pop_q <= SCR_DOUT;
  end

  // occupancy, saturating at both ends
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      depth_q <= '0;
    end else begin
      case (state)
        PUSH:
          if (depth_q != SMAX)
            depth_q <= depth_q + 9'd1;
        POP_WB:
          if (depth_q != 9'd0)
            depth_q <= depth_q - 9'd1;
        LDSP:
          depth_q <= '0;
        default: ;
      endcase
    end
  end

`ifdef STACK_GUARD_EN
  logic err_q;

  // sticky fault flag; only LDSP or reset clears it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                err_q <= 1'b0;
    else if (state == FAULT) err_q <= 1'b1;
    else if (state == LDSP)  err_q <= 1'b0;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign POP_DATA = pop_q;
  assign DEPTH    = depth_q;
  assign FULL     = (depth_q == SMAX);
  assign EMPTY    = (depth_q == 9'd0);

endmodule
